// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Write-side FIFO feeding a parametrised UART transmitter
//             (configurable payload width, parity and stop bits).
//  Ports    : clk      - system clock, rising edge
//             rst      - synchronous reset, active-high
//             data     - write data (DATA_BITS wide)
//             n_wr     - write strobe, active-low, one word per clock
//             n_full   - low when the FIFO holds DEPTH words
//             n_empty  - low when the FIFO holds no words
//             count    - registered number of stored words (0..DEPTH)
//             ovf      - sticky flag, set by a write attempted while full
//             busy     - high while a frame is on the line
//             tx       - UART line, idle high, registered
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int CDIV      = 434,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   data,
  input  logic                   n_wr,
  output logic                   n_full,
  output logic                   n_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic                   busy,
  output logic                   tx
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = (CDIV > 2) ? $clog2(CDIV) : 1;
  localparam int IDXW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 n_full_q;
  logic                 n_empty_q;
  logic                 ovf_q;

  logic                 w_wr_acc;
  logic                 w_wr_drop;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;

  // Acceptance uses the registered full flag from before the edge, so a
  // simultaneous pop never makes room for a write on the same edge.
  assign w_wr_acc  = ~n_wr & n_full_q;
  assign w_wr_drop = ~n_wr & ~n_full_q;
  assign w_head    = mem_q[rd_ptr_q];
  assign count_d   = count_q + CW'(w_wr_acc) - CW'(w_pop);

  // Storage has no reset: contents are only observable after a write.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      n_full_q  <= 1'b1;
      n_empty_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q   <= count_d;
      // Flags derive from the same next count so all three stay consistent.
      n_full_q  <= (count_d != CW'(DEPTH));
      n_empty_q <= (count_d != '0);
      if (w_wr_drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transmitter FSM
  // --------------------------------------------------------------------------
  logic [2:0]           state_q,  state_d;
  logic [CNTW-1:0]      bcnt_q,   bcnt_d;
  logic [IDXW-1:0]      idx_q,    idx_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 par_q,    par_d;
  logic                 tx_q,     tx_d;
  logic                 busy_q,   busy_d;

  logic w_bit_end;
  logic w_last_data;
  logic w_last_stop;
  logic w_par_bit;

  assign w_bit_end   = (bcnt_q == CNTW'(CDIV - 1));
  assign w_last_data = (idx_q == IDXW'(DATA_BITS - 1));
  assign w_last_stop = (idx_q == IDXW'(STOP_BITS - 1));
  // par_q holds the XOR of the payload; odd parity sends its complement.
  assign w_par_bit   = (PARITY == 2) ? par_q : ~par_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (n_empty_q) state_d = S_START;
      end
      S_START: begin
        if (w_bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && w_last_data) begin
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (w_bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Back-to-back frames: a waiting word skips IDLE entirely.
        if (w_bit_end && w_last_stop) begin
          state_d = n_empty_q ? S_START : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: next values of the registered line, counters
  // and shift register, plus the FIFO pop request.
  always_comb begin
    bcnt_d  = w_bit_end ? '0 : bcnt_q + CNTW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    w_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (n_empty_q) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          par_d   = ^w_head;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (w_last_data) begin
            idx_d = '0;
            tx_d  = (PARITY != 0) ? w_par_bit : 1'b1;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (w_bit_end) begin
          tx_d  = 1'b1;
          idx_d = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (w_last_stop) begin
            idx_d = '0;
            if (n_empty_q) begin
              w_pop   = 1'b1;
              shift_d = w_head;
              par_d   = ^w_head;
              tx_d    = 1'b0;
            end else begin
              tx_d   = 1'b1;
              busy_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign n_full  = n_full_q;
  assign n_empty = n_empty_q;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign tx      = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed self-checking bench for uart_tx_fifo. Instance A is
//             8 data bits / even parity / 1 stop, instance B is 7 data bits /
//             odd parity / 2 stop; both DEPTH=4, CDIV=4 (11 bits = 44 clocks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] data_a;
  logic       n_wr_a;
  logic       n_full_a, n_empty_a, ovf_a, busy_a, tx_a;
  logic [2:0] count_a;
  logic [6:0] data_b;
  logic       n_wr_b;
  logic       n_full_b, n_empty_b, ovf_b, busy_b, tx_b;
  logic [2:0] count_b;

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(4), .CDIV(4), .PARITY(2), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .data(data_a), .n_wr(n_wr_a), .n_full(n_full_a),
    .n_empty(n_empty_a), .count(count_a), .ovf(ovf_a), .busy(busy_a), .tx(tx_a));

  uart_tx_fifo #(.DATA_BITS(7), .DEPTH(4), .CDIV(4), .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .data(data_b), .n_wr(n_wr_b), .n_full(n_full_b),
    .n_empty(n_empty_b), .count(count_b), .ovf(ovf_b), .busy(busy_b), .tx(tx_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line decoders: sample the middle of each 4-clock bit of an 11-bit frame.
  logic [7:0] a_q[$];
  logic       a_pq[$];
  logic       a_okq[$];
  int         a_tq[$];
  logic [6:0] b_q[$];
  logic       b_pq[$];
  logic       b_okq[$];

  initial begin
    bit a_act, a_ok, a_par;
    int a_idx, ka;
    logic [7:0] a_sh;
    a_act = 0; a_idx = 0; a_ok = 0; a_par = 0; a_sh = '0;
    forever begin
      @(negedge clk);
      if (rst) a_act = 0;
      else if (!a_act) begin
        if (tx_a === 1'b0) begin
          a_act = 1; a_idx = 0; a_ok = 1; a_tq.push_back(cyc);
        end
      end else begin
        a_idx++;
        if (a_idx % 4 == 2) begin
          ka = a_idx / 4;
          if (ka == 0) a_ok &= (tx_a === 1'b0);
          else if (ka <= 8) a_sh[ka-1] = tx_a;
          else if (ka == 9) a_par = tx_a;
          else a_ok &= (tx_a === 1'b1);
        end
        if (a_idx == 43) begin
          a_q.push_back(a_sh); a_pq.push_back(a_par); a_okq.push_back(a_ok);
          a_act = 0;
        end
      end
    end
  end

  initial begin
    bit b_act, b_ok, b_par;
    int b_idx, kb;
    logic [6:0] b_sh;
    b_act = 0; b_idx = 0; b_ok = 0; b_par = 0; b_sh = '0;
    forever begin
      @(negedge clk);
      if (rst) b_act = 0;
      else if (!b_act) begin
        if (tx_b === 1'b0) begin
          b_act = 1; b_idx = 0; b_ok = 1;
        end
      end else begin
        b_idx++;
        if (b_idx % 4 == 2) begin
          kb = b_idx / 4;
          if (kb == 0) b_ok &= (tx_b === 1'b0);
          else if (kb <= 7) b_sh[kb-1] = tx_b;
          else if (kb == 8) b_par = tx_b;
          else b_ok &= (tx_b === 1'b1);
        end
        if (b_idx == 43) begin
          b_q.push_back(b_sh); b_pq.push_back(b_par); b_okq.push_back(b_ok);
          b_act = 0;
        end
      end
    end
  end

  task automatic wait_idle_a(input int budget, output int took);
    took = 0;
    while (busy_a !== 1'b0 && took < budget) begin
      @(negedge clk);
      took++;
    end
  endtask

  task automatic wait_idle_b(input int budget, output int took);
    took = 0;
    while (busy_b !== 1'b0 && took < budget) begin
      @(negedge clk);
      took++;
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
  endtask

  logic [7:0] t3_words [6];
  logic [7:0] t6_words [4];

  initial begin
    int took, c1;
    bit seen_low, seen_busy;
    t3_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    t6_words = '{8'hA5, 8'h3C, 8'h0F, 8'hC3};

    // Test 1: reset with write strobe held low
    rst = 1'b1; n_wr_a = 1'b0; data_a = 8'hAA; n_wr_b = 1'b0; data_b = 7'h2A;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t1_tx", tx_a, 1);
      check_eq("t1_count", count_a, 0);
      check_eq("t1_n_empty", n_empty_a, 0);
      check_eq("t1_n_full", n_full_a, 1);
      check_eq("t1_ovf", ovf_a, 0);
      check_eq("t1_busy", busy_a, 0);
    end
    check_eq("t1_b_count", count_b, 0);
    rst = 1'b0; n_wr_a = 1'b1; n_wr_b = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t1_no_store", count_a, 0);
    check_eq("t1_still_idle", busy_a, 0);

    // Test 2: single 8'h41 frame, even parity
    a_q.delete(); a_pq.delete(); a_okq.delete(); a_tq.delete();
    data_a = 8'h41; n_wr_a = 1'b0;
    @(negedge clk);
    n_wr_a = 1'b1;
    check_eq("t2_count_e0", count_a, 1);
    check_eq("t2_tx_e0", tx_a, 1);
    @(negedge clk);
    check_eq("t2_tx_e1", tx_a, 0);
    check_eq("t2_busy_e1", busy_a, 1);
    check_eq("t2_count_e1", count_a, 0);
    check_eq("t2_n_empty_e1", n_empty_a, 0);
    wait_idle_a(100, took);
    check_eq("t2_busy_len", took, 44);
    check_eq("t2_frames", a_q.size(), 1);
    check_eq("t2_data", a_q[0], 8'h41);
    check_eq("t2_parity", a_pq[0], 0);
    check_eq("t2_framing", a_okq[0], 1);
    check_eq("t2_tx_idle", tx_a, 1);

    // Test 3: six consecutive writes into DEPTH=4 FIFO
    a_q.delete(); a_pq.delete(); a_okq.delete(); a_tq.delete();
    for (int i = 0; i < 6; i++) begin
      data_a = t3_words[i]; n_wr_a = 1'b0;
      @(negedge clk);
      if (i == 4) begin
        check_eq("t3_count_full", count_a, 4);
        check_eq("t3_n_full", n_full_a, 0);
        check_eq("t3_ovf_pre", ovf_a, 0);
      end
      if (i == 5) begin
        check_eq("t3_ovf", ovf_a, 1);
        check_eq("t3_count_drop", count_a, 4);
      end
    end
    n_wr_a = 1'b1;
    wait_idle_a(400, took);
    check_eq("t3_timeout", took < 400, 1);
    check_eq("t3_frames", a_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_data", a_q[i], t3_words[i]);
      check_eq("t3_framing", a_okq[i], 1);
    end
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_b2b_gap", a_tq[i+1] - a_tq[i], 44);
    end
    check_eq("t3_ovf_sticky", ovf_a, 1);
    check_eq("t3_count_end", count_a, 0);

    // Test 4: instance B, 7 data bits, odd parity, 2 stop bits
    data_b = 7'h7F; n_wr_b = 1'b0;
    @(negedge clk);
    n_wr_b = 1'b1;
    @(negedge clk);
    check_eq("t4_tx_start", tx_b, 0);
    wait_idle_b(100, took);
    check_eq("t4_frame_len", took, 44);
    check_eq("t4_frames", b_q.size(), 1);
    check_eq("t4_data", b_q[0], 7'h7F);
    check_eq("t4_parity", b_pq[0], 0);
    check_eq("t4_framing", b_okq[0], 1);
    data_b = 7'h05; n_wr_b = 1'b0;
    @(negedge clk);
    n_wr_b = 1'b1;
    @(negedge clk);
    wait_idle_b(100, took);
    check_eq("t4b_frames", b_q.size(), 2);
    check_eq("t4b_data", b_q[1], 7'h05);
    check_eq("t4b_parity", b_pq[1], 1);
    check_eq("t4b_framing", b_okq[1], 1);

    // Test 5: reset during data bit 3 with two words queued
    a_q.delete(); a_pq.delete(); a_okq.delete(); a_tq.delete();
    c1 = 0;
    for (int i = 0; i < 3; i++) begin
      data_a = 8'h90 + 8'(i); n_wr_a = 1'b0;
      @(negedge clk);
      if (i == 1) c1 = cyc;
    end
    n_wr_a = 1'b1;
    check_eq("t5_count_q", count_a, 2);
    wait_cyc(c1 + 17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_tx", tx_a, 1);
    check_eq("t5_busy", busy_a, 0);
    check_eq("t5_count", count_a, 0);
    check_eq("t5_n_empty", n_empty_a, 0);
    check_eq("t5_n_full", n_full_a, 1);
    check_eq("t5_ovf_clr", ovf_a, 0);
    seen_low = 0; seen_busy = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_a !== 1'b1) seen_low = 1;
      if (busy_a !== 1'b0) seen_busy = 1;
    end
    check_eq("t5_no_tx", seen_low, 0);
    check_eq("t5_no_busy", seen_busy, 0);
    check_eq("t5_no_frames", a_q.size(), 0);

    // Test 6: write on the same edge the FSM pops, with count=2
    a_q.delete(); a_pq.delete(); a_okq.delete(); a_tq.delete();
    for (int i = 0; i < 3; i++) begin
      data_a = t6_words[i]; n_wr_a = 1'b0;
      @(negedge clk);
      if (i == 1) c1 = cyc;
    end
    n_wr_a = 1'b1;
    check_eq("t6_count_pre", count_a, 2);
    wait_cyc(c1 + 43);
    check_eq("t6_cyc_reached", cyc, c1 + 43);
    check_eq("t6_count_before", count_a, 2);
    data_a = t6_words[3]; n_wr_a = 1'b0;
    @(negedge clk);
    n_wr_a = 1'b1;
    check_eq("t6_count_same", count_a, 2);
    check_eq("t6_next_start", tx_a, 0);
    wait_idle_a(400, took);
    check_eq("t6_timeout", took < 400, 1);
    check_eq("t6_frames", a_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_order", a_q[i], t6_words[i]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
